fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `instructionMemory`. It owns the program counter, drives the memory address each cycle, and captures the 32-bit word returned one cycle later into the fetch/decode pipeline register. The captured word is split into the `OP A B C` fields for the decode stage. The block also handles decode back-pressure, jump redirection with squash, and an optional halt opcode.

## Interface
- `ADDR_W`, 8, program-counter and memory address width.
- `RESET_PC`, 8'h00, PC value loaded at reset.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `STALL`  in  1  decode cannot accept; hold the pipeline register and the fetch.
- `JMP_EN`  in  1  redirect request from a later stage.
- `JMP_ADDR`  in  ADDR_W  jump target.
- `MEM_ADDR`  out  ADDR_W  address to `instructionMemory.addr`; combinational.
- `MEM_DATA`  in  32  `instructionMemory.OUTPUT`, valid one cycle after address.
- `OP_OUT`, `A_OUT`, `B_OUT`, `C_OUT`  out  8 each  bits [31:24], [23:16], [15:8], [7:0] of the captured word.
- `PC_OUT`  out  ADDR_W  address of the instruction held in the output register.
- `VALID_OUT`  out  1  output register holds a real instruction.
- `HALTED`  out  1  fetch stopped on the halt opcode.

## Operation
- Internal state:
  - `pc`: next address to issue.
  - `pc_q`: address issued last cycle.
  - `pending`: the word arriving on `MEM_DATA` this cycle belongs to `pc_q` and is live.
  - Output register.
  - `halted`.
- `MEM_ADDR = STALL ? pc_q : pc`. During a stall the in-flight address is re-issued, so `MEM_DATA` still matches `pc_q` on the next cycle.
- Per rising edge, in priority order:
  - **Jump** (`JMP_EN=1`, overrides everything):
    - `pc<=JMP_ADDR`, `pending<=0`, `VALID_OUT<=0`, `halted<=0`.
    - The in-flight word is squashed.
  - **Stall** (`STALL=1`): all state holds.
  - **Halted**: all state holds, `VALID_OUT<=0`.
  - **Advance** (otherwise):
    - Output register `<= MEM_DATA`.
    - `PC_OUT<=pc_q`, `VALID_OUT<=pending`.
    - `pc_q<=pc`, `pc<=pc+1`, `pending<=1`.
- A jump takes one extra cycle to settle: on the cycle after a jump, `pending=0`, so the word captured then is invalid.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00, with no flag.
- Halt (only with the macro defined):
  - Triggered when an advance captures `MEM_DATA[31:24]==OP_HALT` with `pending=1`.
  - That instruction is presented with `VALID_OUT=1`.
  - Same edge: `halted<=1`, `pending<=0`, `pc` frozen, so the follower word is never presented.
  - Cleared only by `JMP_EN` or reset.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any in-flight word is discarded.

## Timing
- Reset values:
  - `pc=RESET_PC`, `pc_q=RESET_PC`, `pending=0`.
  - `OP/A/B/C_OUT=0`, `PC_OUT=0`, `VALID_OUT=0`, `HALTED=0`.
  - `MEM_ADDR=RESET_PC`.
- First instruction (at `RESET_PC`) shows `VALID_OUT=1` after the 2nd rising edge following `RST` deassertion.
- Steady state: one instruction per cycle, addresses consecutive.
- Jump sampled at edge n: target instruction valid after edge n+2; `VALID_OUT=0` after edges n and n+1.
- Stall: outputs bit-stable for every stalled cycle; the first edge after `STALL` falls resumes at the same address. No instruction is lost or duplicated.
- Simultaneous `JMP_EN` and `STALL`: the jump wins.

## Configuration
- `FETCH_HALT_EN`:
  - **Defined:** halt detection as above.
  - **Undefined:** `OP_HALT` is an ordinary opcode, `HALTED` is tied 0, and the halted state is not built.

## Structure
- Shared package `processor_pkg` holds:
  - `OP_HALT = 8'hFF`.
  - Field bit positions (`OP_MSB`, `A_MSB`, `B_MSB`, `C_MSB`).
  - Instruction width 32.
- One sub-module: `program_counter`, which holds `pc` and `pc_q` and handles load/hold/increment with wrap-around. Pending, halt and the output register stay in `fetch_unit`.

## Test plan
- Reset, then free-run against memory holding word k = {k,k,k,k} → `VALID_OUT` rises after the 2nd edge; `PC_OUT` 0,1,2,… matches `OP_OUT`.
- `STALL` high 3 cycles while `PC_OUT=5` → outputs stay 5 for 3 cycles, then 6,7 with no gap or repeat.
- `JMP_EN` with `JMP_ADDR=8'h40` while `PC_OUT=3` → two cycles `VALID_OUT=0`, then `PC_OUT=8'h40`, `8'h41`; `JMP_EN` together with `STALL` gives the same result.
- Start at `RESET_PC=8'hFE` → `PC_OUT` sequence FE, FF, 00, 01.
- `FETCH_HALT_EN`, word 8'h02 = 32'hFF000000:
  - `PC_OUT=2` presented valid and `HALTED=1`.
  - No further valid output for 10 cycles.
  - Jump to 0 clears `HALTED` and restarts.
- Assert `RST` low mid-stream while `VALID_OUT=1` → all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor constants: instruction layout and special opcodes.
// Used by the fetch stage and its program counter.
package processor_pkg;

  localparam int INSTR_W = 32;
  localparam int FIELD_W = 8;

  localparam int OP_MSB = 31;
  localparam int A_MSB  = 23;
  localparam int B_MSB  = 15;
  localparam int C_MSB  = 7;

  localparam logic [FIELD_W-1:0] OP_HALT = 8'hFF;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-instructionMemory bus: address out, data back one cycle later.
// master = fetch stage, slave = memory.
interface fetch_unit_if
  import processor_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [INSTR_W-1:0] MEM_DATA;

  modport master (
    output MEM_ADDR,
    input  MEM_DATA
  );

  modport slave (
    input  MEM_ADDR,
    output MEM_DATA
  );

endinterface

// File: rtl/program_counter.sv
// Fetch PC pair: pc is the next address to issue, pc_q the one issued last.
// Supports load, hold and wrap-around increment.
module program_counter
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      pc_q <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc_q <= pc;
      pc   <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding decode; optional halt opcode
// detection is built when FETCH_HALT_EN is defined.
module fetch_unit
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALL,
  input  logic               JMP_EN,
  input  logic [ADDR_W-1:0]  JMP_ADDR,
  fetch_unit_if.master       mem,
  output logic [FIELD_W-1:0] OP_OUT,
  output logic [FIELD_W-1:0] A_OUT,
  output logic [FIELD_W-1:0] B_OUT,
  output logic [FIELD_W-1:0] C_OUT,
  output logic [ADDR_W-1:0]  PC_OUT,
  output logic               VALID_OUT,
  output logic               HALTED
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_q;
  logic               pending;
  logic               halted;
  logic               halt_hit;
  logic               pc_inc;
  logic [INSTR_W-1:0] ir;

  assign pc_inc = !JMP_EN && !STALL
               && !halted && !halt_hit;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (JMP_EN),
    .inc       (pc_inc),
    .load_addr (JMP_ADDR),
    .pc        (pc),
    .pc_q      (pc_q)
  );

  // Re-issue the in-flight address so the data still matches pc_q.
  assign mem.MEM_ADDR = STALL ? pc_q : pc;

`ifdef FETCH_HALT_EN
  assign halt_hit = pending &&
    (mem.MEM_DATA[OP_MSB -: FIELD_W] == OP_HALT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      halted <= 1'b0;
    else if (JMP_EN)
      halted <= 1'b0;
    else if (!STALL && !halted && halt_hit)
      halted <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir        <= '0;
      PC_OUT    <= '0;
      VALID_OUT <= 1'b0;
      pending   <= 1'b0;
    end else if (JMP_EN) begin
      VALID_OUT <= 1'b0;
      pending   <= 1'b0;
    end else if (STALL) begin
      pending   <= pending;
    end else if (halted) begin
      VALID_OUT <= 1'b0;
    end else begin
      ir        <= mem.MEM_DATA;
      PC_OUT    <= pc_q;
      VALID_OUT <= pending;
      pending   <= !halt_hit;
    end
  end

  assign OP_OUT = ir[OP_MSB -: FIELD_W];
  assign A_OUT  = ir[A_MSB  -: FIELD_W];
  assign B_OUT  = ir[B_MSB  -: FIELD_W];
  assign C_OUT  = ir[C_MSB  -: FIELD_W];
  assign HALTED = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free-run, stall, jump, wrap, halt
// and asynchronous reset against a registered instruction memory.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       jmp_en;
  logic [7:0] jmp_addr;

  logic [7:0] op_o, a_o, b_o, c_o, pc_o;
  logic       valid_o, halted_o;
  logic [7:0] op2, a2, b2, c2, pc2;
  logic       valid2, halted2;

  logic [31:0] mem [256];
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.ADDR_W(8)) mif1 ();
  fetch_unit_if #(.ADDR_W(8)) mif2 ();

  assign mif1.MEM_DATA = rd1;
  assign mif2.MEM_DATA = rd2;

  always @(posedge clk) begin
    rd1 <= mem[mif1.MEM_ADDR];
    rd2 <= mem[mif2.MEM_ADDR];
  end

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
    .CLK(clk), .RST(rst_n), .STALL(stall),
    .JMP_EN(jmp_en), .JMP_ADDR(jmp_addr), .mem(mif1),
    .OP_OUT(op_o), .A_OUT(a_o), .B_OUT(b_o), .C_OUT(c_o),
    .PC_OUT(pc_o), .VALID_OUT(valid_o), .HALTED(halted_o)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) u_dut2 (
    .CLK(clk), .RST(rst_n), .STALL(1'b0),
    .JMP_EN(1'b0), .JMP_ADDR(8'h00), .mem(mif2),
    .OP_OUT(op2), .A_OUT(a2), .B_OUT(b2), .C_OUT(c2),
    .PC_OUT(pc2), .VALID_OUT(valid2), .HALTED(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       jp;
    logic [7:0] ja;
    logic       v;
    logic [7:0] pc;
    logic       k2;
    logic [7:0] pc2;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic st, logic jp, logic [7:0] ja,
                              logic v, logic [7:0] pc,
                              logic k2, logic [7:0] p2);
    vec_t r;
    r.st = st; r.jp = jp; r.ja = ja;
    r.v = v; r.pc = pc; r.k2 = k2; r.pc2 = p2;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic jp,
                      input logic [7:0] ja);
    stall = st; jmp_en = jp; jmp_addr = ja;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic v,
                         input logic [7:0] pc,
                         input logic [31:0] word);
    chk({name, " valid"}, {31'd0, valid_o}, {31'd0, v});
    if (v) begin
      chk({name, " pc"}, {24'd0, pc_o}, {24'd0, pc});
      chk({name, " word"}, {op_o, a_o, b_o, c_o}, word);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {4{8'(i)}};

    tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    tbl[1]  = mk(0, 0, 8'h00, 1, 8'h00, 1, 8'hFE);
    tbl[2]  = mk(0, 0, 8'h00, 1, 8'h01, 1, 8'hFF);
    tbl[3]  = mk(0, 0, 8'h00, 1, 8'h02, 1, 8'h00);
    tbl[4]  = mk(0, 0, 8'h00, 1, 8'h03, 1, 8'h01);
    tbl[5]  = mk(0, 0, 8'h00, 1, 8'h04, 0, 8'h00);
    tbl[6]  = mk(0, 0, 8'h00, 1, 8'h05, 0, 8'h00);
    tbl[7]  = mk(1, 0, 8'h00, 1, 8'h05, 0, 8'h00);
    tbl[8]  = mk(1, 0, 8'h00, 1, 8'h05, 0, 8'h00);
    tbl[9]  = mk(1, 0, 8'h00, 1, 8'h05, 0, 8'h00);
    tbl[10] = mk(0, 0, 8'h00, 1, 8'h06, 0, 8'h00);
    tbl[11] = mk(0, 0, 8'h00, 1, 8'h07, 0, 8'h00);
    tbl[12] = mk(0, 1, 8'h03, 0, 8'h00, 0, 8'h00);
    tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    tbl[14] = mk(0, 0, 8'h00, 1, 8'h03, 0, 8'h00);
    tbl[15] = mk(0, 1, 8'h40, 0, 8'h00, 0, 8'h00);
    tbl[16] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    tbl[17] = mk(0, 0, 8'h00, 1, 8'h40, 0, 8'h00);
    tbl[18] = mk(0, 0, 8'h00, 1, 8'h41, 0, 8'h00);
    tbl[19] = mk(1, 1, 8'h10, 0, 8'h00, 0, 8'h00);
    tbl[20] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    tbl[21] = mk(0, 0, 8'h00, 1, 8'h10, 0, 8'h00);
    tbl[22] = mk(0, 0, 8'h00, 1, 8'h11, 0, 8'h00);

    rst_n = 1'b0; stall = 1'b0;
    jmp_en = 1'b0; jmp_addr = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst word", {op_o, a_o, b_o, c_o}, 32'h0);
    chk("rst pc", {24'd0, pc_o}, 32'h0);
    chk("rst valid", {31'd0, valid_o}, 32'h0);
    chk("rst halted", {31'd0, halted_o}, 32'h0);
    chk("rst addr", {24'd0, mif1.MEM_ADDR}, 32'h00);
    chk("rst addr2", {24'd0, mif2.MEM_ADDR}, 32'hFE);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].st, tbl[i].jp, tbl[i].ja);
      chk_out($sformatf("vec%0d", i), tbl[i].v,
              tbl[i].pc, {4{tbl[i].pc}});
      chk($sformatf("vec%0d halted", i),
          {31'd0, halted_o}, 32'h0);
      if (tbl[i].k2) begin
        chk($sformatf("wrap%0d valid", i),
            {31'd0, valid2}, 32'h1);
        chk($sformatf("wrap%0d pc", i),
            {24'd0, pc2}, {24'd0, tbl[i].pc2});
        chk($sformatf("wrap%0d op", i),
            {24'd0, op2}, {24'd0, tbl[i].pc2});
      end
    end

    mem[2] = 32'hFF000000;
    step(0, 1, 8'h00);
    chk_out("h jmp0", 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    chk_out("h jmp1", 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    chk_out("h pc0", 1, 8'h00, 32'h00000000);
    step(0, 0, 8'h00);
    chk_out("h pc1", 1, 8'h01, 32'h01010101);
    step(0, 0, 8'h00);
    chk_out("h pc2", 1, 8'h02, 32'hFF000000);
`ifdef FETCH_HALT_EN
    chk("h halted", {31'd0, halted_o}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'h00);
      chk($sformatf("h idle%0d valid", i),
          {31'd0, valid_o}, 32'h0);
      chk($sformatf("h idle%0d halted", i),
          {31'd0, halted_o}, 32'h1);
    end
    mem[2] = 32'h02020202;
    step(0, 1, 8'h00);
    chk("h clr halted", {31'd0, halted_o}, 32'h0);
    chk_out("h clr", 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    chk_out("h clr1", 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    chk_out("h restart0", 1, 8'h00, 32'h00000000);
    step(0, 0, 8'h00);
    chk_out("h restart1", 1, 8'h01, 32'h01010101);
`else
    chk("h halted", {31'd0, halted_o}, 32'h0);
    step(0, 0, 8'h00);
    chk_out("h pc3", 1, 8'h03, 32'h03030303);
    chk("h halted3", {31'd0, halted_o}, 32'h0);
`endif

    chk("pre rst valid", {31'd0, valid_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async word", {op_o, a_o, b_o, c_o}, 32'h0);
    chk("async pc", {24'd0, pc_o}, 32'h0);
    chk("async valid", {31'd0, valid_o}, 32'h0);
    chk("async halted", {31'd0, halted_o}, 32'h0);
    chk("async addr", {24'd0, mif1.MEM_ADDR}, 32'h0);
    chk("async valid2", {31'd0, valid2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    chk_out("rerun0", 0, 8'h00, 32'h0);
    step(0, 0, 8'h00);
    chk_out("rerun1", 1, 8'h00, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
